// File: rtl/cmd_cfg_if.sv
// Command channel between the UART command receiver (master) and cmd_cfg (slave).
interface cmd_cfg_if;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    output cmd_rdy, cmd, data,
    input  clr_cmd_rdy, send_resp, resp
  );

  modport slave (
    input  cmd_rdy, cmd, data,
    output clr_cmd_rdy, send_resp, resp
  );
endinterface

// File: rtl/cmd_cfg.sv
// Command sequencer: decodes host commands into flight setpoints, runs the
// gyro calibration handshake and zeroes setpoints if the host goes silent.
module cmd_cfg #(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  cmd_cfg_if.slave    bus,
  input  logic        cal_done_i,
  output logic [15:0] d_ptch_o,
  output logic [15:0] d_roll_o,
  output logic [15:0] d_yaw_o,
  output logic [8:0]  thrst_o,
  output logic        strt_cal_o,
  output logic        inertial_cal_o,
  output logic        motors_off_o
);

  localparam int unsigned TmrW = FAST_SIM ? 9 : 26;

  localparam logic [7:0] OpPtch  = 8'h02;
  localparam logic [7:0] OpRoll  = 8'h03;
  localparam logic [7:0] OpYaw   = 8'h04;
  localparam logic [7:0] OpThrst = 8'h05;
  localparam logic [7:0] OpCal   = 8'h06;
  localparam logic [7:0] OpLand  = 8'h07;
  localparam logic [7:0] OpOff   = 8'h08;

  localparam logic [7:0] RespAck = 8'hA5;
  localparam logic [7:0] RespNak = 8'hEE;

  typedef enum logic [1:0] {StIdle, StSpinup, StCal, StAck} state_e;

  state_e            state_q, state_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [TmrW-1:0]   wd_q, wd_d;
  logic [15:0]       d_ptch_q, d_ptch_d;
  logic [15:0]       d_roll_q, d_roll_d;
  logic [15:0]       d_yaw_q, d_yaw_d;
  logic [8:0]        thrst_q, thrst_d;
  logic [7:0]        resp_q, resp_d;
  logic              strt_cal_q, strt_cal_d;
  logic              motors_off_q, motors_off_d;
  logic              clr;
  logic              ack;
  logic              in_cal;

  assign in_cal = (state_q == StSpinup) || (state_q == StCal);

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    wd_d         = wd_q;
    d_ptch_d     = d_ptch_q;
    d_roll_d     = d_roll_q;
    d_yaw_d      = d_yaw_q;
    thrst_d      = thrst_q;
    resp_d       = resp_q;
    strt_cal_d   = 1'b0;
    motors_off_d = motors_off_q;
    clr          = 1'b0;
    ack          = 1'b0;

    // Watchdog zeroing comes first so a command loading this cycle overrides it.
    if (wd_q == '1) begin
      d_ptch_d = '0;
      d_roll_d = '0;
      d_yaw_d  = '0;
      thrst_d  = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_rdy) begin
          clr     = 1'b1;
          resp_d  = RespAck;
          state_d = StAck;
          case (bus.cmd)
            OpPtch:  d_ptch_d = bus.data;
            OpRoll:  d_roll_d = bus.data;
            OpYaw:   d_yaw_d  = bus.data;
            OpThrst: thrst_d  = bus.data[8:0];
            OpCal: begin
              motors_off_d = 1'b0;
              tmr_d        = '0;
              state_d      = StSpinup;
            end
            OpLand: begin
              d_ptch_d = '0;
              d_roll_d = '0;
              d_yaw_d  = '0;
              thrst_d  = '0;
            end
            OpOff:   motors_off_d = 1'b1;
            default: resp_d = RespNak;
          endcase
        end
      end
      StSpinup: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == '1) begin
          strt_cal_d = 1'b1;
          state_d    = StCal;
        end
      end
      StCal: begin
        if (cal_done_i) state_d = StAck;
      end
      StAck: begin
        ack     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (clr || in_cal) wd_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tmr_q        <= '0;
      wd_q         <= '0;
      d_ptch_q     <= '0;
      d_roll_q     <= '0;
      d_yaw_q      <= '0;
      thrst_q      <= '0;
      resp_q       <= RespAck;
      strt_cal_q   <= 1'b0;
      motors_off_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      wd_q         <= wd_d;
      d_ptch_q     <= d_ptch_d;
      d_roll_q     <= d_roll_d;
      d_yaw_q      <= d_yaw_d;
      thrst_q      <= thrst_d;
      resp_q       <= resp_d;
      strt_cal_q   <= strt_cal_d;
      motors_off_q <= motors_off_d;
    end
  end

  assign bus.clr_cmd_rdy = clr;
  assign bus.send_resp   = ack;
  assign bus.resp        = resp_q;
  assign d_ptch_o        = d_ptch_q;
  assign d_roll_o        = d_roll_q;
  assign d_yaw_o         = d_yaw_q;
  assign thrst_o         = thrst_q;
  assign strt_cal_o      = strt_cal_q;
  assign inertial_cal_o  = in_cal;
  assign motors_off_o    = motors_off_q;

endmodule

// File: tb/tb_cmd_cfg.sv
// Directed bench for cmd_cfg with FAST_SIM timers (512-cycle spin-up and watchdog).
module tb_cmd_cfg;

  logic        clk;
  logic        rst_n;
  logic        cal_done;
  logic [15:0] d_ptch, d_roll, d_yaw;
  logic [8:0]  thrst;
  logic        strt_cal, inertial_cal, motors_off;

  int checks;
  int failures;

  cmd_cfg_if bus ();

  cmd_cfg #(.FAST_SIM(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .cal_done_i     (cal_done),
    .d_ptch_o       (d_ptch),
    .d_roll_o       (d_roll),
    .d_yaw_o        (d_yaw),
    .thrst_o        (thrst),
    .strt_cal_o     (strt_cal),
    .inertial_cal_o (inertial_cal),
    .motors_off_o   (motors_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one command, holds cmd_rdy until consumed, and records the handshake.
  task automatic issue(input logic [7:0] op, input logic [15:0] dat, output int n_clr,
                       output int n_ack, output logic [7:0] ack_byte, output int lat);
    int clr_at;
    int ack_at;
    n_clr = 0; n_ack = 0; ack_byte = 8'h00; clr_at = -100; ack_at = -200;
    @(posedge clk); #1;
    bus.cmd = op; bus.data = dat; bus.cmd_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.clr_cmd_rdy) begin n_clr++; clr_at = i; end
      if (bus.send_resp) begin n_ack++; ack_at = i; ack_byte = bus.resp; end
      @(posedge clk); #1;
      if (clr_at == i) bus.cmd_rdy = 1'b0;
    end
    lat = ack_at - clr_at;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cal_done = 1'b0;
    bus.cmd_rdy = 1'b0; bus.cmd = 8'h00; bus.data = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({d_ptch, d_roll, d_yaw} !== 48'h0 || thrst !== 9'h0) begin
      failures++; $display("FAIL reset_setpoints got %h %h %h %h want 0", d_ptch, d_roll, d_yaw, thrst); end
    checks++; if ({motors_off, inertial_cal, strt_cal} !== 3'b100) begin
      failures++; $display("FAIL reset_flags got %b want 100", {motors_off, inertial_cal, strt_cal}); end
    checks++; if ({bus.clr_cmd_rdy, bus.send_resp} !== 2'b00 || bus.resp !== 8'hA5) begin
      failures++; $display("FAIL reset_bus got clr=%b ack=%b resp=%h want 0 0 a5",
                           bus.clr_cmd_rdy, bus.send_resp, bus.resp); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_thrust();
    int nc, na, lat; logic [7:0] rb;
    issue(8'h05, 16'h00FF, nc, na, rb, lat);
    checks++; if (thrst !== 9'h0FF) begin failures++; $display("FAIL thrst_load got %h want 0ff", thrst); end
    checks++; if (nc !== 1 || na !== 1 || lat !== 1) begin
      failures++; $display("FAIL thrst_handshake got clr=%0d ack=%0d lat=%0d want 1 1 1", nc, na, lat); end
    checks++; if (rb !== 8'hA5) begin failures++; $display("FAIL thrst_resp got %h want a5", rb); end
    checks++; if (motors_off !== 1'b1) begin failures++; $display("FAIL thrst_motors_off got %b want 1", motors_off); end
  endtask

  task automatic test_attitude();
    int nc, na, lat, acks; logic [7:0] rb;
    acks = 0;
    issue(8'h02, 16'h0100, nc, na, rb, lat); if (rb == 8'hA5 && na == 1) acks++;
    issue(8'h03, 16'hFF80, nc, na, rb, lat); if (rb == 8'hA5 && na == 1) acks++;
    issue(8'h04, 16'h0080, nc, na, rb, lat); if (rb == 8'hA5 && na == 1) acks++;
    checks++; if (d_ptch !== 16'h0100 || d_roll !== 16'hFF80 || d_yaw !== 16'h0080) begin
      failures++; $display("FAIL attitude got %h %h %h want 0100 ff80 0080", d_ptch, d_roll, d_yaw); end
    checks++; if (acks !== 3) begin failures++; $display("FAIL attitude_acks got %0d want 3", acks); end
    checks++; if (thrst !== 9'h0FF) begin failures++; $display("FAIL attitude_thrst got %h want 0ff", thrst); end
  endtask

  task automatic test_calibrate();
    int n; int clr_seen;
    @(posedge clk); #1;
    bus.cmd = 8'h06; bus.data = 16'h0000; bus.cmd_rdy = 1'b1;
    @(negedge clk);
    checks++; if (bus.clr_cmd_rdy !== 1'b1) begin failures++; $display("FAIL cal_clr got %b want 1", bus.clr_cmd_rdy); end
    @(posedge clk); #1;
    bus.cmd_rdy = 1'b0;
    checks++; if (motors_off !== 1'b0 || inertial_cal !== 1'b1) begin
      failures++; $display("FAIL cal_enter got motors_off=%b cal=%b want 0 1", motors_off, inertial_cal); end
    bus.cmd = 8'h05; bus.data = 16'h0033; bus.cmd_rdy = 1'b1;
    n = 0; clr_seen = 0;
    while (strt_cal !== 1'b1 && n < 1000) begin
      @(posedge clk); #1; n++;
      if (bus.clr_cmd_rdy) clr_seen++;
    end
    checks++; if (n !== 512) begin failures++; $display("FAIL cal_spinup_len got %0d want 512", n); end
    @(posedge clk); #1;
    if (bus.clr_cmd_rdy) clr_seen++;
    checks++; if (strt_cal !== 1'b0) begin failures++; $display("FAIL cal_strt_width got %b want 0", strt_cal); end
    repeat (10) begin @(posedge clk); #1; if (bus.clr_cmd_rdy) clr_seen++; end
    checks++; if (clr_seen !== 0 || inertial_cal !== 1'b1 || bus.send_resp !== 1'b0) begin
      failures++; $display("FAIL cal_hold got clr=%0d cal=%b ack=%b want 0 1 0", clr_seen, inertial_cal, bus.send_resp); end
    cal_done = 1'b1;
    @(posedge clk); #1;
    cal_done = 1'b0;
    checks++; if (bus.send_resp !== 1'b1 || bus.resp !== 8'hA5 || inertial_cal !== 1'b0) begin
      failures++; $display("FAIL cal_ack got ack=%b resp=%h cal=%b want 1 a5 0", bus.send_resp, bus.resp, inertial_cal); end
    checks++; if (bus.clr_cmd_rdy !== 1'b0) begin failures++; $display("FAIL cal_ack_clr got %b want 0", bus.clr_cmd_rdy); end
    @(posedge clk); #1;
    checks++; if (bus.clr_cmd_rdy !== 1'b1 || bus.send_resp !== 1'b0) begin
      failures++; $display("FAIL cal_pending got clr=%b ack=%b want 1 0", bus.clr_cmd_rdy, bus.send_resp); end
    @(posedge clk); #1;
    bus.cmd_rdy = 1'b0;
    checks++; if (thrst !== 9'h033 || bus.send_resp !== 1'b1) begin
      failures++; $display("FAIL cal_pending_load got thrst=%h ack=%b want 033 1", thrst, bus.send_resp); end
  endtask

  task automatic test_emergency();
    int nc, na, lat; logic [7:0] rb;
    issue(8'h07, 16'hBEEF, nc, na, rb, lat);
    checks++; if ({d_ptch, d_roll, d_yaw} !== 48'h0 || thrst !== 9'h0) begin
      failures++; $display("FAIL land_zero got %h %h %h %h want 0", d_ptch, d_roll, d_yaw, thrst); end
    checks++; if (rb !== 8'hA5 || na !== 1 || motors_off !== 1'b0) begin
      failures++; $display("FAIL land_ack got resp=%h acks=%0d motors_off=%b want a5 1 0", rb, na, motors_off); end
    issue(8'h08, 16'h0000, nc, na, rb, lat);
    checks++; if (motors_off !== 1'b1 || rb !== 8'hA5) begin
      failures++; $display("FAIL motors_off got %b resp=%h want 1 a5", motors_off, rb); end
  endtask

  task automatic test_unknown();
    int nc, na, lat; logic [7:0] rb;
    issue(8'h02, 16'h1234, nc, na, rb, lat);
    issue(8'h1F, 16'hFFFF, nc, na, rb, lat);
    checks++; if (rb !== 8'hEE || na !== 1 || nc !== 1) begin
      failures++; $display("FAIL unknown_resp got resp=%h acks=%0d clr=%0d want ee 1 1", rb, na, nc); end
    checks++; if (d_ptch !== 16'h1234 || thrst !== 9'h0 || motors_off !== 1'b1) begin
      failures++; $display("FAIL unknown_regs got ptch=%h thrst=%h off=%b want 1234 0 1", d_ptch, thrst, motors_off); end
  endtask

  task automatic test_watchdog();
    int acks;
    @(posedge clk); #1;
    bus.cmd = 8'h05; bus.data = 16'hFF00; bus.cmd_rdy = 1'b1;
    @(posedge clk); #1;
    bus.cmd_rdy = 1'b0;
    checks++; if (thrst !== 9'h100 || bus.send_resp !== 1'b1) begin
      failures++; $display("FAIL wd_load got thrst=%h ack=%b want 100 1", thrst, bus.send_resp); end
    acks = 0;
    for (int n = 1; n <= 520; n++) begin
      @(posedge clk); #1;
      if (bus.send_resp) acks++;
      if (n == 511) begin
        checks++; if (thrst !== 9'h100 || d_ptch !== 16'h1234) begin
          failures++; $display("FAIL wd_early got thrst=%h ptch=%h want 100 1234", thrst, d_ptch); end
      end
      if (n == 512) begin
        checks++; if (thrst !== 9'h0 || d_ptch !== 16'h0) begin
          failures++; $display("FAIL wd_fire got thrst=%h ptch=%h want 0 0", thrst, d_ptch); end
      end
    end
    checks++; if (acks !== 0) begin failures++; $display("FAIL wd_no_resp got %0d want 0", acks); end
  endtask

  task automatic test_reset_mid_cal();
    int nc, na, lat; logic [7:0] rb;
    issue(8'h02, 16'h0777, nc, na, rb, lat);
    issue(8'h06, 16'h0000, nc, na, rb, lat);
    repeat (100) @(posedge clk);
    #1;
    checks++; if (inertial_cal !== 1'b1 || motors_off !== 1'b0) begin
      failures++; $display("FAIL rstcal_pre got cal=%b off=%b want 1 0", inertial_cal, motors_off); end
    rst_n = 1'b0;
    #1;
    checks++; if (inertial_cal !== 1'b0 || motors_off !== 1'b1 || strt_cal !== 1'b0 || d_ptch !== 16'h0) begin
      failures++; $display("FAIL rstcal_abort got cal=%b off=%b strt=%b ptch=%h want 0 1 0 0",
                           inertial_cal, motors_off, strt_cal, d_ptch); end
    checks++; if (bus.resp !== 8'hA5 || bus.send_resp !== 1'b0) begin
      failures++; $display("FAIL rstcal_bus got resp=%h ack=%b want a5 0", bus.resp, bus.send_resp); end
    @(negedge clk); rst_n = 1'b1;
    issue(8'h05, 16'h0155, nc, na, rb, lat);
    checks++; if (thrst !== 9'h155 || lat !== 1 || rb !== 8'hA5) begin
      failures++; $display("FAIL rstcal_resume got thrst=%h lat=%0d resp=%h want 155 1 a5", thrst, lat, rb); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_thrust();
    test_attitude();
    test_calibrate();
    test_emergency();
    test_unknown();
    test_watchdog();
    test_reset_mid_cal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
